exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the in-order pipeline. It sits directly upstream of the memory stage and registers that stage's inputs: ALU result / address, store data, destination register and control. Single-cycle integer ALU operations complete every cycle. An optional RV32M unit adds a single-cycle multiply and a 32-iteration restoring divider, which stalls the upstream stage through `in_ready` while it runs.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `arst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  kill the instruction being accepted, any in-flight divide, and the output slot.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage can accept this cycle; low while the divider is busy.
- `alu_op`  in  4  operation code (see Operation).
- `opr_a`, `opr_b`  in  32  operands.
- `store_data`  in  32  rs2 value for stores, passed through.
- `rd_in`  in  5, `rf_en_in`  in  1, `dm_en_in`  in  1, `wb_sel_in`  in  2  control, passed through.
- `out_valid`  out  1  output slot holds a real instruction.
- `opr_res`  out  32  result or address, to the memory stage.
- `opr_b_out`  out  32  registered `store_data`.
- `rd`  out  5, `rf_en`  out  1, `dm_en`  out  1, `wb_sel`  out  2  registered control.

## Operation
- Accept: `in_valid && in_ready && !flush`.
- ALU codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (result = `opr_b`).
  - Shift amount is `opr_b[4:0]`.
  - All arithmetic is modulo 2^32.
- M codes:
  - 11 MUL: low 32 bits of the product.
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- FSM states `IDLE` and `DIV`. `in_ready = (state == IDLE)`.
- IDLE, non-divide accepted: output registers load the result and pass-through fields, `out_valid=1`.
- IDLE, divide accepted with `opr_b != 0`:
  - Latch operand magnitudes, result signs, op, and pass-through fields.
  - Counter = 31; go to `DIV`.
  - Output slot loads a bubble.
- Divide by zero: completes like a normal ALU op with no FSM entry.
  - Quotient = 0xFFFFFFFF; remainder = `opr_a`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): handled by the normal iteration path.
  - Must yield quotient 0x80000000, remainder 0.
- DIV state:
  - One restoring step per cycle; counter decrements.
  - When counter is 0 at an edge: apply the sign fix-up (quotient negative iff signs differ; remainder takes the dividend's sign), load the output slot with `out_valid=1`, return to IDLE.
  - Non-final DIV cycles load a bubble.
- Bubble: `out_valid=0`, `rf_en=0`, `dm_en=0`, all other outputs 0. A bubble is loaded whenever nothing is accepted and no divide completes.
- `flush` (synchronous):
  - Next edge loads a bubble and sets state to IDLE, aborting any divide.
  - Flush wins over accept and over divide completion in the same cycle.
- There is no downstream backpressure; the memory stage always consumes.

## Timing
- Reset (`arst_n=0` at an edge): state IDLE, counter 0, all outputs 0. `in_ready=1` in the first cycle after reset.
- Reset during `DIV` aborts the divide; the same applies to flush.
- ALU/MUL latency: 1 cycle; accept at edge N, output valid after edge N.
- Divide latency: accept at edge N; result valid after edge N+32.
  - `in_ready=0` for the 32 cycles between edges N and N+32.
  - Upstream holds its next instruction until `in_ready=1` again.
- Divide-by-zero latency: 1 cycle.
- Back-to-back ALU ops: one per cycle, no bubbles.
- A second divide can be accepted in the cycle after a divide completes.

## Configuration
- `MULDIV_EN` defined:
  - Codes 11–15 implemented as above.
  - FSM, counter and divider datapath present.
- `MULDIV_EN` undefined:
  - Codes 11–15 produce `opr_res=0` in 1 cycle, with the pass-through fields still registered.
  - `in_ready` is tied to 1; no FSM or divider logic exists.

## Test plan
- Reset then ADD 5+7, rd=3, rf_en=1 -> one edge later: `out_valid=1`, `opr_res=12`, `rd=3`, `rf_en=1`.
- SRA 0x80000000 by 4, then SLTU 1 vs 0xFFFFFFFF on consecutive cycles -> 0xF8000000 then 1 on consecutive cycles, no bubble.
- DIV −7/2 (MULDIV_EN) -> `in_ready` low for 32 cycles, bubbles meanwhile; then `opr_res` = 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
- DIVU 10/0 -> 0xFFFFFFFF after 1 cycle, `in_ready` never drops. REM 0x80000000 / 0xFFFFFFFF -> 0 after 32 cycles.
- Start DIVU 100/3, assert `flush` at cycle 10 -> bubble, IDLE, `in_ready=1` next cycle, no result emitted. Repeat using `arst_n=0` instead of `flush` -> all outputs 0.
- Without MULDIV_EN: MUL 3×4 -> `opr_res=0` after 1 cycle, `in_ready` constantly 1.

Source files
------------

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Purpose  : Execute stage; registers ALU result and control for the memory
//            stage. Define MULDIV_EN for the RV32M multiply / restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] opr_a,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [4:0]            rd_in,
    input  logic                  rf_en_in,
    input  logic                  dm_en_in,
    input  logic [1:0]            wb_sel_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] opr_res,
    output logic [DATA_WIDTH-1:0] opr_b_out,
    output logic [4:0]            rd,
    output logic                  rf_en,
    output logic                  dm_en,
    output logic [1:0]            wb_sel
);
    localparam logic [3:0] c_ADD  = 4'd0,  c_SUB  = 4'd1,  c_SLL   = 4'd2,  c_SLT  = 4'd3;
    localparam logic [3:0] c_SLTU = 4'd4,  c_XOR  = 4'd5,  c_SRL   = 4'd6,  c_SRA  = 4'd7;
    localparam logic [3:0] c_OR   = 4'd8,  c_AND  = 4'd9,  c_PASSB = 4'd10, c_MUL  = 4'd11;
    localparam logic [3:0] c_DIV  = 4'd12, c_DIVU = 4'd13, c_REM   = 4'd14, c_REMU = 4'd15;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_nxt_valid, w_nxt_rf_en, w_nxt_dm_en;
    logic [DATA_WIDTH-1:0] w_nxt_res, w_nxt_b;
    logic [4:0]            w_nxt_rd;
    logic [1:0]            w_nxt_wb_sel;

    assign w_accept = in_valid && w_in_ready && !flush;
    assign in_ready = w_in_ready;

    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            c_ADD:   w_alu_res = opr_a + opr_b;
            c_SUB:   w_alu_res = opr_a - opr_b;
            c_SLL:   w_alu_res = opr_a << opr_b[4:0];
            c_SLT:   w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(opr_a) < $signed(opr_b))};
            c_SLTU:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (opr_a < opr_b)};
            c_XOR:   w_alu_res = opr_a ^ opr_b;
            c_SRL:   w_alu_res = opr_a >> opr_b[4:0];
            c_SRA:   w_alu_res = $signed(opr_a) >>> opr_b[4:0];
            c_OR:    w_alu_res = opr_a | opr_b;
            c_AND:   w_alu_res = opr_a & opr_b;
            c_PASSB: w_alu_res = opr_b;
            default: w_alu_res = '0;
        endcase
    end

`ifdef MULDIV_EN
    typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;

    state_t                r_state, w_state_next;
    logic [4:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_quo, r_rem, r_dvsr, r_sd_l;
    logic                  r_neg_q, r_neg_r, r_is_rem, r_rf_en_l, r_dm_en_l;
    logic [4:0]            r_rd_l;
    logic [1:0]            r_wb_sel_l;

    logic                  w_is_div, w_b_zero, w_signed, w_a_neg, w_b_neg;
    logic                  w_div_start;
    logic [DATA_WIDTH-1:0] w_a_mag, w_b_mag, w_ex_res;
    logic [DATA_WIDTH:0]   w_rem_sh, w_diff;
    logic [DATA_WIDTH-1:0] w_quo_step, w_rem_step, w_q_fix, w_r_fix;

    assign w_in_ready = (r_state == IDLE);
    assign w_is_div   = (alu_op >= c_DIV);
    assign w_b_zero   = (opr_b == '0);
    assign w_signed   = (alu_op == c_DIV) || (alu_op == c_REM);
    assign w_a_neg    = w_signed & opr_a[DATA_WIDTH-1];
    assign w_b_neg    = w_signed & opr_b[DATA_WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~opr_a + 1'b1) : opr_a;
    assign w_b_mag    = w_b_neg ? (~opr_b + 1'b1) : opr_b;

    // One restoring step: shift the next dividend bit in, keep the difference if non-negative.
    assign w_rem_sh   = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvsr};
    assign w_quo_step = {r_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
    assign w_rem_step = w_diff[DATA_WIDTH] ? w_rem_sh[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
    assign w_q_fix    = r_neg_q ? (~w_quo_step + 1'b1) : w_quo_step;
    assign w_r_fix    = r_neg_r ? (~w_rem_step + 1'b1) : w_rem_step;

    always_comb begin
        w_ex_res = w_alu_res;
        case (alu_op)
            c_MUL:         w_ex_res = opr_a * opr_b;
            c_DIV, c_DIVU: w_ex_res = w_b_zero ? '1 : '0;
            c_REM, c_REMU: w_ex_res = w_b_zero ? opr_a : '0;
            default:       w_ex_res = w_alu_res;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_div_start  = 1'b0;
        w_nxt_valid  = 1'b0;
        w_nxt_res    = '0;
        w_nxt_b      = '0;
        w_nxt_rd     = '0;
        w_nxt_rf_en  = 1'b0;
        w_nxt_dm_en  = 1'b0;
        w_nxt_wb_sel = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_div && !w_b_zero) begin
                        w_div_start  = 1'b1;
                        w_state_next = DIV;
                    end else begin
                        w_nxt_valid  = 1'b1;
                        w_nxt_res    = w_ex_res;
                        w_nxt_b      = store_data;
                        w_nxt_rd     = rd_in;
                        w_nxt_rf_en  = rf_en_in;
                        w_nxt_dm_en  = dm_en_in;
                        w_nxt_wb_sel = wb_sel_in;
                    end
                end
            end
            DIV: begin
                if (r_cnt == 5'd0) begin
                    w_state_next = IDLE;
                    w_nxt_valid  = 1'b1;
                    w_nxt_res    = r_is_rem ? w_r_fix : w_q_fix;
                    w_nxt_b      = r_sd_l;
                    w_nxt_rd     = r_rd_l;
                    w_nxt_rf_en  = r_rf_en_l;
                    w_nxt_dm_en  = r_dm_en_l;
                    w_nxt_wb_sel = r_wb_sel_l;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // Flush overrides both a new accept and a completing divide.
        if (flush) begin
            w_state_next = IDLE;
            w_div_start  = 1'b0;
            w_nxt_valid  = 1'b0;
            w_nxt_res    = '0;
            w_nxt_b      = '0;
            w_nxt_rd     = '0;
            w_nxt_rf_en  = 1'b0;
            w_nxt_dm_en  = 1'b0;
            w_nxt_wb_sel = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvsr     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_rem   <= 1'b0;
            r_sd_l     <= '0;
            r_rd_l     <= '0;
            r_rf_en_l  <= 1'b0;
            r_dm_en_l  <= 1'b0;
            r_wb_sel_l <= '0;
        end else if (w_div_start) begin
            r_cnt      <= 5'd31;
            r_quo      <= w_a_mag;
            r_rem      <= '0;
            r_dvsr     <= w_b_mag;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_is_rem   <= alu_op[1];
            r_sd_l     <= store_data;
            r_rd_l     <= rd_in;
            r_rf_en_l  <= rf_en_in;
            r_dm_en_l  <= dm_en_in;
            r_wb_sel_l <= wb_sel_in;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (r_state == DIV) begin
            r_quo <= w_quo_step;
            r_rem <= w_rem_step;
            if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end
`else
    assign w_in_ready = 1'b1;

    always_comb begin
        w_nxt_valid  = 1'b0;
        w_nxt_res    = '0;
        w_nxt_b      = '0;
        w_nxt_rd     = '0;
        w_nxt_rf_en  = 1'b0;
        w_nxt_dm_en  = 1'b0;
        w_nxt_wb_sel = '0;
        if (w_accept) begin
            w_nxt_valid  = 1'b1;
            w_nxt_res    = w_alu_res;
            w_nxt_b      = store_data;
            w_nxt_rd     = rd_in;
            w_nxt_rf_en  = rf_en_in;
            w_nxt_dm_en  = dm_en_in;
            w_nxt_wb_sel = wb_sel_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            out_valid <= 1'b0;
            opr_res   <= '0;
            opr_b_out <= '0;
            rd        <= '0;
            rf_en     <= 1'b0;
            dm_en     <= 1'b0;
            wb_sel    <= '0;
        end else begin
            out_valid <= w_nxt_valid;
            opr_res   <= w_nxt_res;
            opr_b_out <= w_nxt_b;
            rd        <= w_nxt_rd;
            rf_en     <= w_nxt_rf_en;
            dm_en     <= w_nxt_dm_en;
            wb_sel    <= w_nxt_wb_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage
// Purpose  : Self-checking bench for exe_stage (table vectors + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage;
    logic        clk;
    logic        arst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] opr_a, opr_b, store_data;
    logic [4:0]  rd_in;
    logic        rf_en_in, dm_en_in;
    logic [1:0]  wb_sel_in;
    logic        out_valid;
    logic [31:0] opr_res, opr_b_out;
    logic [4:0]  rd;
    logic        rf_en, dm_en;
    logic [1:0]  wb_sel;

    exe_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .arst_n(arst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opr_a(opr_a), .opr_b(opr_b), .store_data(store_data),
        .rd_in(rd_in), .rf_en_in(rf_en_in), .dm_en_in(dm_en_in), .wb_sel_in(wb_sel_in),
        .out_valid(out_valid), .opr_res(opr_res), .opr_b_out(opr_b_out),
        .rd(rd), .rf_en(rf_en), .dm_en(dm_en), .wb_sel(wb_sel)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [31:0] sd;
        logic [8:0]  ctrl;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tg    = 8'd3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Present one instruction; its result is expected lat edges after the current one.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        in_valid   = 1'b1;
        flush      = 1'b0;
        alu_op     = op;
        opr_a      = a;
        opr_b      = b;
        store_data = a ^ {tg, 24'hA5C3E1};
        rd_in      = tg[4:0];
        rf_en_in   = 1'b1;
        dm_en_in   = tg[0];
        wb_sel_in  = tg[2:1];
        e.cyc  = cyc + lat;
        e.res  = exp;
        e.sd   = store_data;
        e.ctrl = {rd_in, rf_en_in, dm_en_in, wb_sel_in};
        sb.push_back(e);
        tg++;
    endtask

    task automatic busy_check();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            check("in_ready_busy", in_ready, 0);
        end
        @(negedge clk);
        check("in_ready_release", in_ready, 1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missing_output_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("opr_res", opr_res, e.res);
                check("opr_b_out", opr_b_out, e.sd);
                check("ctrl", {rd, rf_en, dm_en, wb_sel}, e.ctrl);
            end
        end else begin
            check("bubble", {out_valid, opr_res, opr_b_out, rd, rf_en, dm_en, wb_sel}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_op = '0;
        opr_a = '0; opr_b = '0; store_data = '0;
        rd_in = '0; rf_en_in = 1'b0; dm_en_in = 1'b0; wb_sel_in = '0;

        tbl.push_back('{4'd0,  32'd5,          32'd7,          32'd12});
        tbl.push_back('{4'd7,  32'h8000_0000,  32'd4,          32'hF800_0000});
        tbl.push_back('{4'd4,  32'd1,          32'hFFFF_FFFF,  32'd1});
        tbl.push_back('{4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE});
        tbl.push_back('{4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0});
        tbl.push_back('{4'd2,  32'd1,          32'h0000_003F,  32'h8000_0000});
        tbl.push_back('{4'd3,  32'hFFFF_FFFF,  32'd1,          32'd1});
        tbl.push_back('{4'd3,  32'd5,          32'd3,          32'd0});
        tbl.push_back('{4'd4,  32'hFFFF_FFFF,  32'd1,          32'd0});
        tbl.push_back('{4'd5,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0});
        tbl.push_back('{4'd6,  32'h8000_0000,  32'd4,          32'h0800_0000});
        tbl.push_back('{4'd8,  32'h00FF_0000,  32'h0000_00FF,  32'h00FF_00FF});
        tbl.push_back('{4'd9,  32'h1234_5678,  32'h0F0F_0F0F,  32'h0204_0608});
        tbl.push_back('{4'd10, 32'h1111_1111,  32'hDEAD_BEEF,  32'hDEAD_BEEF});
`ifdef MULDIV_EN
        tbl.push_back('{4'd11, 32'd3,          32'd4,          32'd12});
        tbl.push_back('{4'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1});
        tbl.push_back('{4'd13, 32'd10,         32'd0,          32'hFFFF_FFFF});
        tbl.push_back('{4'd15, 32'd10,         32'd0,          32'd10});
        tbl.push_back('{4'd14, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB});
        tbl.push_back('{4'd12, 32'd7,          32'd0,          32'hFFFF_FFFF});
`else
        tbl.push_back('{4'd11, 32'd3,          32'd4,          32'd0});
        tbl.push_back('{4'd12, 32'd7,          32'd2,          32'd0});
        tbl.push_back('{4'd13, 32'd10,         32'd0,          32'd0});
        tbl.push_back('{4'd14, 32'd9,          32'd4,          32'd0});
        tbl.push_back('{4'd15, 32'd9,          32'd4,          32'd0});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);
        check("reset_outputs", {out_valid, opr_res, opr_b_out, rd, rf_en, dm_en, wb_sel}, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1);
            check("in_ready_single_cycle", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Flush in the same cycle as an offered instruction: nothing is accepted.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd0; opr_a = 32'd1; opr_b = 32'd1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("in_ready_after_flush_accept", in_ready, 1);
        repeat (3) @(negedge clk);

`ifdef MULDIV_EN
        @(negedge clk);
        drive(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        @(negedge clk);
        drive(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 65);
        busy_check();
        @(negedge clk);
        drive(4'd0, 32'd2, 32'd2, 32'd4, 33);
        busy_check();
        @(negedge clk);
        drive(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        @(negedge clk);
        drive(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 65);
        busy_check();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);

        // DIVU 100/3 aborted by flush ten cycles in.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd13; opr_a = 32'd100; opr_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("in_ready_before_flush", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("in_ready_after_flush", in_ready, 1);
        repeat (40) @(negedge clk);

        // Same abort through reset.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd13; opr_a = 32'd100; opr_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("in_ready_before_reset", in_ready, 0);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        check("in_ready_after_reset", in_ready, 1);
        check("outputs_after_reset", {out_valid, opr_res, opr_b_out, rd, rf_en, dm_en, wb_sel}, 0);
        repeat (40) @(negedge clk);
`else
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(4'd11 + 4'(k), 32'd3, 32'd4, 32'd0, 1);
            check("in_ready_no_muldiv", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
